csr_irq_unit: RTL and testbench

Machine-mode CSR file and interrupt/trap controller for the 3-stage RV32 pipeline, generalising the single-interrupt CSR block to `NUM_IRQ` prioritised external interrupt lines. It sits in the memory/writeback stage and executes CSRRW/CSRRS/CSRRC and MRET. It synchronises and latches interrupt requests, arbitrates by priority and performs trap entry/exit. It drives a registered one-cycle PC redirect to the fetch stage.

---
 rtl/csr_pkg.sv | 56 +++++
 rtl/csr_irq_arbiter.sv | 21 ++
 rtl/csr_irq_unit.sv | 177 +++++++++++++++++
 tb/tb_csr_irq_unit.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared constants and helpers for the machine-mode CSR / interrupt unit.
package csr_pkg;

    // CSR addresses
    localparam logic [11:0] CsrMstatus  = 12'h300;
    localparam logic [11:0] CsrMie      = 12'h304;
    localparam logic [11:0] CsrMtvec    = 12'h305;
    localparam logic [11:0] CsrMscratch = 12'h340;
    localparam logic [11:0] CsrMepc     = 12'h341;
    localparam logic [11:0] CsrMcause   = 12'h342;
    localparam logic [11:0] CsrMip      = 12'h344;
    localparam logic [11:0] CsrMcycle   = 12'hB00;
    localparam logic [11:0] CsrMcycleh  = 12'hB80;

    typedef enum logic [1:0] {
        CsrOpNone = 2'd0,
        CsrOpRw   = 2'd1,
        CsrOpRs   = 2'd2,
        CsrOpRc   = 2'd3
    } csr_op_e;

    localparam int unsigned MstatusMieBit  = 3;
    localparam int unsigned MstatusMpieBit = 7;

    // External line i reports cause / mip / mie bit IrqCauseBase + i
    localparam int unsigned IrqCauseBase = 16;

    localparam logic [31:0] MstatusMppRo = 32'h0000_1800;
    localparam logic [31:0] MtvecWmask   = 32'hFFFF_FFFD;
    localparam logic [31:0] MepcWmask    = 32'hFFFF_FFFC;

    // Writable mie bits for a given number of interrupt lines
    function automatic logic [31:0] mie_wmask(int unsigned n);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < int'(n)) m[IrqCauseBase + i] = 1'b1;
        end
        return m;
    endfunction

    // Read-modify-write value before field masking
    function automatic logic [31:0] csr_update(csr_op_e op, logic [31:0] old_val,
                                               logic [31:0] wdata);
        logic [31:0] r;
        r = old_val;
        case (op)
            CsrOpRw: r = wdata;
            CsrOpRs: r = old_val | wdata;
            CsrOpRc: r = old_val & ~wdata;
            default: r = old_val;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/csr_irq_arbiter.sv
// Fixed-priority interrupt arbiter: lowest pending line index wins.
module csr_irq_arbiter
    import csr_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0] pend,
    output logic               any,
    output logic [3:0]         idx
);

    // Scan from the top so the lowest set index is the last assignment
    always_comb begin
        any = |pend;
        idx = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (pend[i]) idx = 4'(i);
        end
    end

endmodule

// File: rtl/csr_irq_unit.sv
// Machine-mode CSR file and prioritised interrupt/trap controller for the MW stage.
// Optional build macro CSR_IRQ_CYCLE_COUNTER_EN adds the 64-bit mcycle/mcycleh counter.
module csr_irq_unit
    import csr_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic [1:0]         csr_op,
    input  logic [11:0]        csr_addr,
    input  logic [31:0]        csr_wdata,
    input  logic               is_mret,
    input  logic [31:0]        pc,
    input  logic [NUM_IRQ-1:0] irq,
    output logic [31:0]        csr_rdata,
    output logic               csr_illegal,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc
);

    localparam logic [31:0] MieWmask = mie_wmask(NUM_IRQ);

    logic [NUM_IRQ-1:0] irq_s1_q, irq_s2_q;
    logic               mstatus_mie_q, mstatus_mpie_q;
    logic [31:0]        mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic               redirect_valid_q;
    logic [31:0]        redirect_pc_q;

    csr_op_e            op;
    logic [31:0]        mip, rdata, wval;
    logic               addr_legal, trap, csr_we, mret;
    logic [NUM_IRQ-1:0] pend_lines;
    logic               irq_any;
    logic [3:0]         irq_idx;
    logic [31:0]        cause_num, trap_base, trap_pc;

`ifdef CSR_IRQ_CYCLE_COUNTER_EN
    logic [63:0]        mcycle_q, mcycle_d;
`endif

    assign op         = csr_op_e'(csr_op);
    assign pend_lines = irq_s2_q & mie_q[IrqCauseBase +: NUM_IRQ];

    csr_irq_arbiter #(
        .NUM_IRQ (NUM_IRQ)
    ) u_arb (
        .pend (pend_lines),
        .any  (irq_any),
        .idx  (irq_idx)
    );

    // Two-flop synchroniser for the asynchronous request lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_s1_q <= '0;
            irq_s2_q <= '0;
        end else begin
            irq_s1_q <= irq;
            irq_s2_q <= irq_s1_q;
        end
    end

    // Zero-latency CSR read mux and address decode
    always_comb begin
        mip = '0;
        mip[IrqCauseBase +: NUM_IRQ] = irq_s2_q;
        rdata      = '0;
        addr_legal = 1'b1;
        case (csr_addr)
            CsrMstatus: begin
                rdata = MstatusMppRo;
                rdata[MstatusMieBit]  = mstatus_mie_q;
                rdata[MstatusMpieBit] = mstatus_mpie_q;
            end
            CsrMie:      rdata = mie_q;
            CsrMtvec:    rdata = mtvec_q;
            CsrMscratch: rdata = mscratch_q;
            CsrMepc:     rdata = mepc_q;
            CsrMcause:   rdata = mcause_q;
            CsrMip:      rdata = mip;
`ifdef CSR_IRQ_CYCLE_COUNTER_EN
            CsrMcycle:   rdata = mcycle_q[31:0];
            CsrMcycleh:  rdata = mcycle_q[63:32];
`endif
            default:     addr_legal = 1'b0;
        endcase
    end

    assign csr_rdata   = rdata;
    assign csr_illegal = !addr_legal && (op != CsrOpNone);
    assign wval        = csr_update(op, rdata, csr_wdata);

    // The MW instruction is squashed while a redirect is in flight; a trap pre-empts it
    assign trap   = instr_valid && mstatus_mie_q && irq_any && !redirect_valid_q;
    assign csr_we = instr_valid && (op != CsrOpNone) && addr_legal && !trap && !redirect_valid_q;
    assign mret   = instr_valid && is_mret && !trap && !redirect_valid_q;

    assign cause_num = 32'(IrqCauseBase) + 32'(irq_idx);
    assign trap_base = {mtvec_q[31:2], 2'b00};
    assign trap_pc   = mtvec_q[0] ? trap_base + (cause_num << 2) : trap_base;

    // CSR state: trap entry first, otherwise the committed CSR write or MRET
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
        end else if (trap) begin
            mepc_q         <= pc & MepcWmask;
            mcause_q       <= {1'b1, cause_num[30:0]};
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
        end else begin
            if (csr_we) begin
                case (csr_addr)
                    CsrMstatus: begin
                        mstatus_mie_q  <= wval[MstatusMieBit];
                        mstatus_mpie_q <= wval[MstatusMpieBit];
                    end
                    CsrMie:      mie_q      <= wval & MieWmask;
                    CsrMtvec:    mtvec_q    <= wval & MtvecWmask;
                    CsrMscratch: mscratch_q <= wval;
                    CsrMepc:     mepc_q     <= wval & MepcWmask;
                    CsrMcause:   mcause_q   <= wval;
                    default: ;
                endcase
            end
            if (mret) begin
                mstatus_mie_q  <= mstatus_mpie_q;
                mstatus_mpie_q <= 1'b1;
            end
        end
    end

    // One-cycle registered PC redirect to fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            redirect_valid_q <= trap || mret;
            if (trap) begin
                redirect_pc_q <= trap_pc;
            end else if (mret) begin
                redirect_pc_q <= mepc_q;
            end
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

`ifdef CSR_IRQ_CYCLE_COUNTER_EN
    // Free-running counter; a write to either half wins over the increment for that half
    always_comb begin
        mcycle_d = mcycle_q + 64'd1;
        if (csr_we && (csr_addr == CsrMcycle))  mcycle_d[31:0]  = wval;
        if (csr_we && (csr_addr == CsrMcycleh)) mcycle_d[63:32] = wval;
    end

    // Cycle counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle_q <= '0;
        end else begin
            mcycle_q <= mcycle_d;
        end
    end
`endif

endmodule

// File: tb/tb_csr_irq_unit.sv
// Self-checking bench for csr_irq_unit: directed scenarios plus randomized traffic
// compared against a behavioural model of the CSR/trap rules.
module tb_csr_irq_unit;

    localparam int NUM_IRQ = 4;

    logic               clk;
    logic               rst_n;
    logic               instr_valid;
    logic [1:0]         csr_op;
    logic [11:0]        csr_addr;
    logic [31:0]        csr_wdata;
    logic               is_mret;
    logic [31:0]        pc;
    logic [NUM_IRQ-1:0] irq;
    logic [31:0]        csr_rdata;
    logic               csr_illegal;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;

    int checks   = 0;
    int failures = 0;

    csr_irq_unit #(
        .NUM_IRQ (NUM_IRQ)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_valid    (instr_valid),
        .csr_op         (csr_op),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .is_mret        (is_mret),
        .pc             (pc),
        .irq            (irq),
        .csr_rdata      (csr_rdata),
        .csr_illegal    (csr_illegal),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    logic               m_mie, m_mpie, m_rv;
    logic [NUM_IRQ-1:0] m_en;
    logic [NUM_IRQ-1:0] m_irq_seen[2];   // [0]: one edge ago, [1]: two edges ago
    logic [31:0]        m_mtvec, m_mscratch, m_mepc, m_mcause, m_rpc;

    logic [31:0] obs_rdata, exp_rdata;
    logic        obs_illegal, exp_illegal;

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_rv = 0; m_en = '0;
        m_irq_seen[0] = '0; m_irq_seen[1] = '0;
        m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_rpc = 0;
    endtask

    task automatic model_read(input logic [11:0] a, output logic legal, output logic [31:0] v);
        legal = 1'b1;
        case (a)
            12'h300: v = 32'h1800 + (32'(m_mpie) * 128) + (32'(m_mie) * 8);
            12'h304: v = 32'(m_en) << 16;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h344: v = 32'(m_irq_seen[1]) << 16;
            default: begin legal = 1'b0; v = 0; end
        endcase
    endtask

    task automatic model_step(input logic v, input logic [1:0] op, input logic [11:0] a,
                              input logic [31:0] wd, input logic mr, input logic [31:0] p,
                              input logic [NUM_IRQ-1:0] ir);
        logic               legal;
        logic [31:0]        old_v, nv;
        logic [NUM_IRQ-1:0] pend;
        int                 win;
        pend = m_irq_seen[1] & m_en;
        model_read(a, legal, old_v);
        if (m_rv) begin
            m_rv = 0;
        end else if (v && m_mie && pend != 0) begin
            win = -1;
            for (int i = 0; i < NUM_IRQ; i++) if (pend[i] && win < 0) win = i;
            m_mepc   = p & ~32'h3;
            m_mcause = 32'h8000_0000 | 32'(16 + win);
            m_rpc    = (m_mtvec & ~32'h3) + (m_mtvec[0] ? 32'(4 * (16 + win)) : 32'h0);
            m_mpie   = m_mie;
            m_mie    = 0;
            m_rv     = 1;
        end else begin
            m_rv = 0;
            if (v && op != 0 && legal) begin
                nv = (op == 1) ? wd : (op == 2) ? (old_v | wd) : (old_v & ~wd);
                case (a)
                    12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                    12'h304: m_en = nv[16 +: NUM_IRQ];
                    12'h305: m_mtvec = nv & 32'hFFFF_FFFD;
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc = nv & ~32'h3;
                    12'h342: m_mcause = nv;
                    default: ;
                endcase
            end
            if (v && mr) begin
                m_mie = m_mpie; m_mpie = 1; m_rv = 1; m_rpc = m_mepc;
            end
        end
        m_irq_seen[1] = m_irq_seen[0];
        m_irq_seen[0] = ir;
    endtask

    // One clock: drive at negedge, capture combinational read, advance model, return at negedge
    task automatic cycle(input logic v, input logic [1:0] op, input logic [11:0] a,
                         input logic [31:0] wd, input logic mr, input logic [31:0] p,
                         input logic [NUM_IRQ-1:0] ir);
        logic        lg;
        logic [31:0] val;
        instr_valid = v; csr_op = op; csr_addr = a; csr_wdata = wd;
        is_mret = mr; pc = p; irq = ir;
        #1;
        obs_rdata   = csr_rdata;
        obs_illegal = csr_illegal;
        model_read(a, lg, val);
        exp_rdata   = lg ? val : 32'h0;
        exp_illegal = !lg && (op != 0);
        @(posedge clk);
        model_step(v, op, a, wd, mr, p, ir);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        instr_valid = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
        is_mret = 0; pc = 0; irq = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (redirect_valid !== 1'b0) begin
            failures++; $display("FAIL reset_rv: got %b want 0", redirect_valid);
        end
        cycle(0, 0, 12'h300, 0, 0, 0, '0);
        checks++;
        if (obs_rdata !== 32'h1800) begin
            failures++; $display("FAIL reset_mstatus: got %h want 00001800", obs_rdata);
        end
        cycle(0, 0, 12'h304, 0, 0, 0, '0);
        checks++;
        if (obs_rdata !== 32'h0) begin
            failures++; $display("FAIL reset_mie: got %h want 0", obs_rdata);
        end
        cycle(0, 0, 12'h342, 0, 0, 0, '0);
        checks++;
        if (obs_rdata !== 32'h0 || redirect_pc !== 32'h0) begin
            failures++; $display("FAIL reset_mcause: got %h/%h want 0/0", obs_rdata, redirect_pc);
        end
    endtask

    task automatic test_irq_trap();
        cycle(1, 1, 12'h304, 32'h0003_0000, 0, 32'h10, '0);
        cycle(1, 1, 12'h305, 32'h201, 0, 32'h14, '0);
        cycle(1, 2, 12'h300, 32'h8, 0, 32'h18, '0);
        cycle(0, 0, 12'h000, 0, 0, 0, 4'b0010);
        cycle(0, 0, 12'h000, 0, 0, 0, 4'b0010);
        cycle(1, 0, 12'h000, 0, 0, 32'h100, 4'b0010);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h244) begin
            failures++;
            $display("FAIL trap_redirect: got %b/%h want 1/00000244", redirect_valid, redirect_pc);
        end
        cycle(1, 0, 12'h341, 0, 0, 32'h104, 4'b0010);
        checks++;
        if (obs_rdata !== 32'h100) begin
            failures++; $display("FAIL trap_mepc: got %h want 00000100", obs_rdata);
        end
        checks++;
        if (redirect_valid !== 1'b0) begin
            failures++; $display("FAIL trap_pulse: got %b want 0", redirect_valid);
        end
        cycle(0, 0, 12'h342, 0, 0, 0, 4'b0010);
        checks++;
        if (obs_rdata !== 32'h8000_0011) begin
            failures++; $display("FAIL trap_mcause: got %h want 80000011", obs_rdata);
        end
        cycle(0, 0, 12'h300, 0, 0, 0, 4'b0010);
        checks++;
        if (obs_rdata !== 32'h1880) begin
            failures++; $display("FAIL trap_mstatus: got %h want 00001880", obs_rdata);
        end
    endtask

    task automatic test_priority();
        cycle(1, 1, 12'h305, 32'h200, 0, 32'h120, 4'b0011);
        cycle(0, 0, 12'h000, 0, 0, 0, 4'b0011);
        cycle(0, 0, 12'h000, 0, 0, 0, 4'b0011);
        cycle(1, 2, 12'h300, 32'h8, 0, 32'h124, 4'b0011);
        checks++;
        if (redirect_valid !== 1'b0) begin
            failures++; $display("FAIL prio_no_early_trap: got %b want 0", redirect_valid);
        end
        cycle(1, 0, 12'h000, 0, 0, 32'h180, 4'b0011);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200) begin
            failures++;
            $display("FAIL prio_redirect: got %b/%h want 1/00000200", redirect_valid, redirect_pc);
        end
        cycle(0, 0, 12'h342, 0, 0, 0, 4'b0011);
        checks++;
        if (obs_rdata !== 32'h8000_0010) begin
            failures++; $display("FAIL prio_mcause: got %h want 80000010", obs_rdata);
        end
    endtask

    task automatic test_mret();
        cycle(1, 1, 12'h341, 32'h104, 0, 32'h200, 4'b0011);
        cycle(1, 0, 12'h000, 0, 1, 32'h204, 4'b0011);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h104) begin
            failures++;
            $display("FAIL mret_redirect: got %b/%h want 1/00000104", redirect_valid, redirect_pc);
        end
        cycle(1, 0, 12'h300, 0, 0, 32'h208, 4'b0011);
        checks++;
        if (obs_rdata !== 32'h1888) begin
            failures++; $display("FAIL mret_mstatus: got %h want 00001888", obs_rdata);
        end
        cycle(1, 0, 12'h000, 0, 0, 32'h104, 4'b0011);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200) begin
            failures++;
            $display("FAIL mret_retrap: got %b/%h want 1/00000200", redirect_valid, redirect_pc);
        end
    endtask

    task automatic test_trap_suppress();
        cycle(0, 0, 12'h000, 0, 0, 0, 4'b0011);
        cycle(1, 1, 12'h340, 32'h1234, 0, 32'h300, 4'b0011);
        cycle(1, 2, 12'h300, 32'h8, 0, 32'h304, 4'b0011);
        cycle(1, 1, 12'h340, 32'hDEAD, 0, 32'h308, 4'b0011);
        checks++;
        if (redirect_valid !== 1'b1) begin
            failures++; $display("FAIL suppress_trap: got %b want 1", redirect_valid);
        end
        cycle(0, 0, 12'h340, 0, 0, 0, 4'b0011);
        checks++;
        if (obs_rdata !== 32'h1234) begin
            failures++; $display("FAIL suppress_mscratch: got %h want 00001234", obs_rdata);
        end
        cycle(1, 2, 12'h7C0, 32'h0, 0, 32'h30C, 4'b0011);
        checks++;
        if (obs_illegal !== 1'b1 || obs_rdata !== 32'h0) begin
            failures++;
            $display("FAIL illegal_addr: got %b/%h want 1/00000000", obs_illegal, obs_rdata);
        end
    endtask

    task automatic test_async_reset();
        cycle(1, 0, 12'h000, 0, 1, 32'h400, 4'b0011);
        checks++;
        if (redirect_valid !== 1'b1) begin
            failures++; $display("FAIL areset_setup: got %b want 1", redirect_valid);
        end
        csr_addr = 12'h300;
        rst_n = 0;
        #1;
        checks++;
        if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0 || csr_rdata !== 32'h1800) begin
            failures++;
            $display("FAIL areset_clear: got %b/%h/%h want 0/00000000/00001800",
                     redirect_valid, redirect_pc, csr_rdata);
        end
        model_reset();
        irq = '0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_cycle_counter();
        do_reset();
`ifdef CSR_IRQ_CYCLE_COUNTER_EN
        cycle(1, 1, 12'hB00, 32'hFFFF_FFFE, 0, 32'h10, '0);
        cycle(1, 1, 12'hB80, 32'h0, 0, 32'h14, '0);
        cycle(0, 0, 12'hB00, 0, 0, 0, '0);
        checks++;
        if (obs_rdata !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL mcycle_pre_wrap: got %h want ffffffff", obs_rdata);
        end
        cycle(0, 0, 12'hB00, 0, 0, 0, '0);
        checks++;
        if (obs_rdata !== 32'h0) begin
            failures++; $display("FAIL mcycle_wrap: got %h want 0", obs_rdata);
        end
        cycle(0, 0, 12'hB80, 0, 0, 0, '0);
        checks++;
        if (obs_rdata !== 32'h1) begin
            failures++; $display("FAIL mcycleh_carry: got %h want 1", obs_rdata);
        end
`else
        cycle(1, 2, 12'hB00, 0, 0, 32'h10, '0);
        checks++;
        if (obs_illegal !== 1'b1 || obs_rdata !== 32'h0) begin
            failures++; $display("FAIL mcycle_absent: got %b/%h want 1/0", obs_illegal, obs_rdata);
        end
        cycle(1, 2, 12'hB80, 0, 0, 32'h14, '0);
        checks++;
        if (obs_illegal !== 1'b1 || obs_rdata !== 32'h0) begin
            failures++; $display("FAIL mcycleh_absent: got %b/%h want 1/0", obs_illegal, obs_rdata);
        end
`endif
    endtask

    task automatic test_random();
        logic [11:0]        addrs[9];
        logic [NUM_IRQ-1:0] cur_irq;
        logic [1:0]         op;
        logic               v, mr;
        addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                  12'h7C0, 12'h123};
        do_reset();
        cur_irq = '0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(7) == 0) cur_irq = NUM_IRQ'($urandom);
            v  = ($urandom_range(3) != 0);
            op = 2'($urandom_range(3));
            mr = (op == 0) && ($urandom_range(7) == 0);
            cycle(v, op, addrs[$urandom_range(8)], $urandom, mr, $urandom & ~32'h3, cur_irq);
            checks++;
            if (obs_rdata !== exp_rdata || obs_illegal !== exp_illegal) begin
                failures++;
                $display("FAIL rand_read[%0d]: got %h/%b want %h/%b", n, obs_rdata, obs_illegal,
                         exp_rdata, exp_illegal);
            end
            checks++;
            if (redirect_valid !== m_rv || (m_rv && redirect_pc !== m_rpc)) begin
                failures++;
                $display("FAIL rand_redirect[%0d]: got %b/%h want %b/%h", n, redirect_valid,
                         redirect_pc, m_rv, m_rpc);
            end
        end
    endtask

    initial begin
        rst_n = 0;
        instr_valid = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
        is_mret = 0; pc = 0; irq = '0;
        model_reset();
        test_reset();
        test_irq_trap();
        test_priority();
        test_mret();
        test_trap_suppress();
        test_async_reset();
        test_cycle_counter();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
